// File: rtl/uart_program_loader.sv
// Purpose: 8N1 UART boot loader. It takes a count word and data words and writes them to program memory. It holds the core in reset until the image is complete.
// Latency: a byte is seen about 9.5 bit periods plus 2 cycles after its start edge. The write strobe follows the 4th byte of a word by one cycle.
// Backpressure: none. The serial line cannot be stalled, and bytes arriving after completion or an error are dropped.
// Option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte after the data words.
module uart_program_loader #(
    parameter int CLK_FREQ  = 100_000_000,
    parameter int BAUD      = 115_200,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_rx,
    output logic        pmem_write_enable,
    output logic [31:0] pmem_address,
    output logic [31:0] pmem_write_data,
    output logic        cpu_reset_n,
    output logic        load_done,
    output logic        load_error
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW  = $clog2(CLKS_PER_BIT + 1);
    localparam int WCW = $clog2(MEM_WORDS + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    typedef enum logic [2:0] {
        L_COUNT,
        L_DATA,
`ifdef LOADER_CHECKSUM_EN
        L_CHECK,
`endif
        L_DONE,
        L_ERROR
    } load_state_t;

`ifdef LOADER_CHECKSUM_EN
    localparam load_state_t FINAL_STATE = L_CHECK;
`else
    localparam load_state_t FINAL_STATE = L_DONE;
`endif

    // serial receiver
    logic          rx_meta, rx_s, rx_prev;
    rx_state_t     rx_state, rx_next;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          byte_valid, frame_err;
    logic          half_tick, bit_tick;

    // loader
    load_state_t    l_state, l_next;
    logic [23:0]    count_reg;
    logic [31:0]    count_full;
    logic [WCW-1:0] count_words, words_done;
    logic [1:0]     byte_idx;
    logic           last_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]     csum;
`endif

    assign half_tick  = (rx_state == RX_START) && (clk_cnt == HALF_LAST);
    assign bit_tick   = ((rx_state == RX_DATA) || (rx_state == RX_STOP)) && (clk_cnt == BIT_LAST);
    assign count_full = {shift, count_reg};
    assign last_word  = (words_done + 1'b1) == count_words;

    // Two-flop synchroniser plus a delayed copy used for start-edge detection.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= io_rx;
            rx_s    <= rx_meta;
            rx_prev <= rx_s;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (!reset_n) rx_state <= RX_IDLE;
        else          rx_state <= rx_next;
    end

    // Receiver next state. A start bit that is high at mid-bit is treated as a glitch.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_prev && !rx_s) rx_next = RX_START;
            RX_START: if (half_tick) rx_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:  if (bit_tick && (bit_idx == 3'd7)) rx_next = RX_STOP;
            RX_STOP:  if (bit_tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // Bit timing, LSB-first shift register, and one-cycle byte/framing-error pulses.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if ((rx_state != rx_next) || (rx_state == RX_IDLE) || bit_tick)
                clk_cnt <= '0;
            else
                clk_cnt <= clk_cnt + 1'b1;
            if ((rx_state == RX_DATA) && bit_tick) begin
                shift   <= {rx_s, shift[7:1]};
                bit_idx <= bit_idx + 1'b1;
            end
            if ((rx_state == RX_STOP) && bit_tick) begin
                byte_valid <= rx_s;
                frame_err  <= !rx_s;
            end
        end
    end

    // Loader state register.
    always_ff @(posedge clk) begin
        if (!reset_n) l_state <= L_COUNT;
        else          l_state <= l_next;
    end

    // Loader next state and status outputs. Framing errors are fatal until the image is done.
    always_comb begin
        l_next      = l_state;
        load_done   = 1'b0;
        load_error  = 1'b0;
        cpu_reset_n = 1'b0;
        case (l_state)
            L_COUNT: begin
                if (byte_valid && (byte_idx == 2'd3)) begin
                    if (count_full == 32'd0)                 l_next = FINAL_STATE;
                    else if (count_full > 32'(MEM_WORDS))    l_next = L_ERROR;
                    else                                     l_next = L_DATA;
                end
            end
            L_DATA: begin
                if (pmem_write_enable && last_word) l_next = FINAL_STATE;
            end
`ifdef LOADER_CHECKSUM_EN
            L_CHECK: begin
                if (byte_valid) l_next = (shift == csum) ? L_DONE : L_ERROR;
            end
`endif
            L_DONE: begin
                load_done   = 1'b1;
                cpu_reset_n = 1'b1;
            end
            L_ERROR: begin
                load_error = 1'b1;
            end
            default: l_next = L_ERROR;
        endcase
        if (frame_err && (l_state != L_DONE)) l_next = L_ERROR;
    end

    // Loader datapath: count assembly, word assembly, write strobe, and address/word counters.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count_reg         <= '0;
            count_words       <= '0;
            words_done        <= '0;
            byte_idx          <= '0;
            pmem_write_enable <= 1'b0;
            pmem_address      <= '0;
            pmem_write_data   <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum              <= '0;
`endif
        end else begin
            pmem_write_enable <= 1'b0;
            if (pmem_write_enable) begin
                pmem_address <= pmem_address + 32'd4;
                words_done   <= words_done + 1'b1;
            end
            if (byte_valid && ((l_state == L_COUNT) || (l_state == L_DATA))) begin
                byte_idx <= byte_idx + 1'b1;
`ifdef LOADER_CHECKSUM_EN
                csum     <= csum ^ shift;
`endif
                if (l_state == L_COUNT) begin
                    // Little-endian: after three bytes, count_reg holds {b2, b1, b0}.
                    count_reg <= {shift, count_reg[23:8]};
                    if (byte_idx == 2'd3) count_words <= count_full[WCW-1:0];
                end else begin
                    pmem_write_data[{byte_idx, 3'b000} +: 8] <= shift;
                    if (byte_idx == 2'd3) pmem_write_enable <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_program_loader.sv
// Bench for uart_program_loader at 10 clocks per bit: a vector table, hand-written corner sequences, and random images.
// Expected writes and status come from an image-level model of the byte stream.
// Build with LOADER_CHECKSUM_EN defined to exercise the trailing checksum byte.
module tb_uart_program_loader;
    localparam int CPB = 10;
`ifdef LOADER_CHECKSUM_EN
    localparam bit CSUM = 1'b1;
`else
    localparam bit CSUM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        io_rx = 1'b1;
    logic        pmem_write_enable;
    logic [31:0] pmem_address, pmem_write_data;
    logic        cpu_reset_n, load_done, load_error;

    uart_program_loader #(.CLK_FREQ(1_000_000), .BAUD(100_000), .MEM_WORDS(1024)) dut (
        .clk(clk), .reset_n(reset_n), .io_rx(io_rx),
        .pmem_write_enable(pmem_write_enable), .pmem_address(pmem_address),
        .pmem_write_data(pmem_write_data), .cpu_reset_n(cpu_reset_n),
        .load_done(load_done), .load_error(load_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_we_cyc, done_cyc, last_start_cyc, overlap;
    bit prev_done;
    logic [31:0] got_a[$], got_d[$];
    logic [7:0]  stim_b[$];
    bit          stim_g[$];
    logic [31:0] exp_a[$], exp_d[$];
    bit          exp_done, exp_err;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture write strobes and completion timing away from the active edge.
    always @(negedge clk) begin
        if (pmem_write_enable) begin
            got_a.push_back(pmem_address);
            got_d.push_back(pmem_write_data);
            last_we_cyc = cyc;
        end
        if (load_done && !prev_done) done_cyc = cyc;
        if (load_done && pmem_write_enable) overlap++;
        prev_done = load_done;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic do_reset(input bit chk);
        reset_n = 1'b0;
        io_rx = 1'b1;
        repeat (3) @(negedge clk);
        if (chk) begin
            check("rst we", pmem_write_enable, 0);
            check("rst addr", pmem_address, 0);
            check("rst data", pmem_write_data, 0);
            check("rst cpu_reset_n", cpu_reset_n, 0);
            check("rst done", load_done, 0);
            check("rst error", load_error, 0);
        end
        got_a = {};
        got_d = {};
        done_cyc = -1;
        last_we_cyc = -1;
        overlap = 0;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit good);
        last_start_cyc = cyc;
        io_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            io_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        io_rx = good;
        repeat (CPB) @(negedge clk);
        io_rx = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Stream: count word, 'sent' data words, and an optional checksum byte (inverted in bit 0 when flip).
    // A 'bad' index >= 0 marks that post-count byte with a low stop bit.
    task automatic build(input logic [31:0] count, input int sent, input int bad,
                         input logic [31:0] w0, input logic [31:0] w1, input bit flip);
        logic [31:0] w;
        logic [7:0]  x;
        stim_b = {};
        stim_g = {};
        x = 8'h00;
        for (int k = 0; k < 4; k++) begin
            stim_b.push_back(count[8*k +: 8]);
            stim_g.push_back(1'b1);
        end
        for (int j = 0; j < sent; j++) begin
            w = (j == 0) ? w0 : (j == 1) ? w1 : $urandom;
            for (int k = 0; k < 4; k++) begin
                stim_b.push_back(w[8*k +: 8]);
                stim_g.push_back(1'b1);
            end
        end
        if (CSUM) begin
            foreach (stim_b[i]) x ^= stim_b[i];
            stim_b.push_back(x ^ {7'd0, flip});
            stim_g.push_back(1'b1);
        end
        if (bad >= 0 && bad + 4 < stim_b.size()) stim_g[bad + 4] = 1'b0;
    endtask

    // Image-level interpretation of the byte stream.
    task automatic model();
        logic [31:0] cnt, word;
        logic [7:0]  x;
        int nb, nw;
        exp_done = 0;
        exp_err = 0;
        exp_a = {};
        exp_d = {};
        cnt = 0;
        word = 0;
        x = 0;
        nb = 0;
        nw = 0;
        foreach (stim_b[i]) begin
            if (exp_done || exp_err) continue;
            if (!stim_g[i]) begin
                exp_err = 1;
                continue;
            end
            if (nb < 4) begin
                cnt = cnt | (32'(stim_b[i]) << (8 * nb));
                x ^= stim_b[i];
                nb++;
                if (nb == 4) begin
                    if (cnt > 32'd1024) exp_err = 1;
                    else if (cnt == 0 && !CSUM) exp_done = 1;
                end
            end else if (nw < int'(cnt)) begin
                word = word | (32'(stim_b[i]) << (8 * ((nb - 4) % 4)));
                x ^= stim_b[i];
                nb++;
                if ((nb - 4) % 4 == 0) begin
                    exp_a.push_back(32'(nw * 4));
                    exp_d.push_back(word);
                    word = 0;
                    nw++;
                    if (nw == int'(cnt) && !CSUM) exp_done = 1;
                end
            end else begin
                if (stim_b[i] == x) exp_done = 1;
                else exp_err = 1;
            end
        end
    endtask

    task automatic run_stream();
        foreach (stim_b[i]) send_byte(stim_b[i], stim_g[i]);
        repeat (40) @(negedge clk);
    endtask

    task automatic check_writes(input string tag);
        check({tag, " nwrites"}, got_a.size(), exp_a.size());
        for (int i = 0; i < got_a.size() && i < exp_a.size(); i++) begin
            check($sformatf("%s addr%0d", tag, i), got_a[i], exp_a[i]);
            check($sformatf("%s data%0d", tag, i), got_d[i], exp_d[i]);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, " done"}, load_done, exp_done);
        check({tag, " error"}, load_error, exp_err);
        check({tag, " cpu_reset_n"}, cpu_reset_n, exp_done);
        check_writes(tag);
    endtask

    typedef struct {
        logic [31:0] count;
        int          sent;
        int          bad;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          exp_done;
        bit          exp_err;
        int          exp_n;
    } vec_t;

    vec_t tbl[7];

    initial begin
        tbl[0] = '{32'd2,    2, -1, 32'h0000_0013, 32'h0010_0093, 1'b1, 1'b0, 2}; // two-word image
        tbl[1] = '{32'd0,    0, -1, 32'h0,         32'h0,         1'b1, 1'b0, 0}; // empty image
        tbl[2] = '{32'd1,    1,  0, 32'hDEAD_BEEF, 32'h0,         1'b0, 1'b1, 0}; // framing error on data
        tbl[3] = '{32'd1025, 0, -1, 32'h0,         32'h0,         1'b0, 1'b1, 0}; // oversize count
        tbl[4] = '{32'd1024, 0, -1, 32'h0,         32'h0,         1'b0, 1'b0, 0}; // maximum count accepted
        tbl[5] = '{32'd0,    1,  0, 32'h1234_5678, 32'h0,         1'b1, 1'b0, 0}; // bad byte after done ignored
        tbl[6] = '{32'd1,    2, -1, 32'hCAFE_F00D, 32'h1111_2222, 1'b1, 1'b0, 1}; // extra word after done ignored

        do_reset(1'b1);

`ifndef LOADER_CHECKSUM_EN
        for (int t = 0; t < 7; t++) begin
            do_reset(1'b0);
            build(tbl[t].count, tbl[t].sent, tbl[t].bad, tbl[t].w0, tbl[t].w1, 1'b0);
            model();
            run_stream();
            check($sformatf("vec%0d done", t), load_done, tbl[t].exp_done);
            check($sformatf("vec%0d error", t), load_error, tbl[t].exp_err);
            check($sformatf("vec%0d cpu_reset_n", t), cpu_reset_n, tbl[t].exp_done);
            check($sformatf("vec%0d nwrites", t), got_a.size(), tbl[t].exp_n);
            check_writes($sformatf("vec%0d", t));
            if (t == 0) begin
                check("vec0 done after strobe", done_cyc, last_we_cyc + 1);
                check("vec0 done/strobe overlap", overlap, 0);
            end
            if (t == 1) begin
                check("vec1 done latency in window",
                      (done_cyc - last_start_cyc >= 85) && (done_cyc - last_start_cyc <= 115), 1);
            end
        end
`endif

        // A 3-cycle low glitch must not start a byte; the next image still loads correctly.
        do_reset(1'b0);
        io_rx = 1'b0;
        repeat (3) @(negedge clk);
        io_rx = 1'b1;
        repeat (30) @(negedge clk);
        check("glitch done", load_done, 0);
        check("glitch error", load_error, 0);
        build(32'd1, 1, -1, 32'hA5A5_0F0F, 32'h0, 1'b0);
        model();
        run_stream();
        check_model("glitch load");

        // Reset after one word of a two-word image; a new image restarts at address 0.
        do_reset(1'b0);
        build(32'd2, 1, -1, 32'h0000_0013, 32'h0, 1'b0);
        if (CSUM) void'(stim_b.pop_back());
        run_stream();
        check("midload nwrites", got_a.size(), 1);
        check("midload addr", pmem_address, 32'd4);
        do_reset(1'b1);
        build(32'd2, 2, -1, 32'h0000_0013, 32'h0010_0093, 1'b0);
        model();
        run_stream();
        check_model("after reset");
        check("after reset done", load_done, 1);

`ifdef LOADER_CHECKSUM_EN
        do_reset(1'b0);
        build(32'd2, 2, -1, 32'h0000_0013, 32'h0010_0093, 1'b0);
        model();
        run_stream();
        check("csum ok done", load_done, 1);
        check("csum ok cpu_reset_n", cpu_reset_n, 1);
        check_writes("csum ok");
        do_reset(1'b0);
        build(32'd2, 2, -1, 32'h0000_0013, 32'h0010_0093, 1'b1);
        model();
        run_stream();
        check("csum bad error", load_error, 1);
        check("csum bad cpu_reset_n", cpu_reset_n, 0);
        check("csum bad nwrites", got_a.size(), 2);
        check_writes("csum bad");
`endif

        // Random images: small counts, occasional oversize counts, framing errors and extra words.
        for (int r = 0; r < 12; r++) begin
            logic [31:0] cnt;
            int sent, bad;
            do_reset(1'b0);
            cnt = 32'($urandom_range(1, 3));
            sent = int'(cnt) + (($urandom_range(0, 3) == 0) ? 1 : 0);
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sent * 4 - 1)) : -1;
            if ($urandom_range(0, 5) == 0) begin
                cnt = 32'd1024 + 32'($urandom_range(1, 100));
                sent = 0;
                bad = -1;
            end
            build(cnt, sent, bad, $urandom, $urandom, 1'($urandom_range(0, 1) == 0 ? 0 : (CSUM && r % 3 == 0)));
            model();
            run_stream();
            check_model($sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
